mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer beside the EX-stage ALU in the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs a 32-step iterative shift-add or restoring-divide datapath. It owns the HI/LO architectural registers and raises busy so hazard logic stalls the pipeline. Exception flush cancels an in-flight operation without touching HI/LO.

Parameters:
WIDTH, 32, operand/HI/LO width
CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  EX issues mdu_op_i this cycle
mdu_op_i  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
opnd1_i  in  WIDTH  rs value (multiplicand/dividend/MTHI-MTLO data)
opnd2_i  in  WIDTH  rt value (multiplier/divisor)
flush_i  in  1  exception/flush, cancels operation
busy_o  out  1  state != IDLE; hazard unit stalls MFHI/MFLO and new MDU ops
done_o  out  1  one-cycle pulse when HI/LO are written by MUL/DIV
hi_o  out  WIDTH  HI register
lo_o  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, hi_o=0, lo_o=0, busy_o=0, done_o=0, internal accumulators 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1:
  - MULT/MULTU -> MUL, cnt=0.
  - DIV/DIVU -> DIV, cnt=0.
  - MTHI/MTLO: hi_o/lo_o = opnd1_i at that edge; stay IDLE; busy_o stays 0.
  - NONE: no effect.
- Signed ops (MULT, DIV): latch |opnd1|, |opnd2|, neg_q = sign1^sign2, neg_r = sign1. Unsigned ops latch raw operands.
- MUL: one shift-add step per cycle for 32 cycles (cnt 0..31); at cnt=31 -> DONE.
- DIV: one restoring step per cycle (shift remainder, trial-subtract, set quotient bit) for 32 cycles; at cnt=31 -> DONE.
- DONE (one cycle): apply sign fix (product negated if neg_q; quotient negated if neg_q; remainder negated if neg_r); MUL writes HI=product[63:32], LO=product[31:0]; DIV writes LO=quotient, HI=remainder; done_o=1; -> IDLE.
- Latency: start edge at T -> busy_o high T+1..T+33; HI/LO new values visible from T+34; done_o high during T+33.
- Divide by zero, both signed and unsigned: no trap; LO=32'hFFFFFFFF, HI=opnd1_i as issued (unsigned form); same 32+1 cycle latency.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (natural result of the magnitude algorithm).
- start_i while busy_o=1: ignored; the hazard unit guarantees this never happens; bench asserts it.
- flush_i=1 in any state: next state IDLE, cnt=0, done_o=0, HI/LO unchanged. flush_i with start_i in the same cycle: flush wins, op discarded, including MTHI/MTLO.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
MDU_FAST_MUL_EN
- Defined: MULT/MULTU use a single-cycle WIDTH x WIDTH multiply. IDLE -> DONE directly, so busy_o is high for 1 cycle and HI/LO are visible at T+2. Sign handling is unchanged. DIV is unaffected.
- Undefined: iterative 32-cycle multiply as above.

Decomposition:
- Shared constants header (alongside existing const.vh): MDU_OP_* encodings (3-bit), MDU state encodings, and the divide-by-zero LO value.
- One natural sub-module: mdu_iter_step. It is the combinational single-step datapath: shift-add for MUL, shift-subtract for DIV, selected by a mode bit. It outputs the next accumulator, next remainder and quotient bit.
- mdu_ctrl holds the FSM, counter, operand latches, sign fix-up and HI/LO registers.

Test Plan:
- MULT opnd1=0xFFFFFFFE, opnd2=3 -> busy_o 33 cycles, done_o pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU opnd1=0xFFFFFFFE, opnd2=3 -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV opnd1=0xFFFFFFF9 (-7), opnd2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
- DIVU opnd1=0x12345678, opnd2=0 -> LO=0xFFFFFFFF, HI=0x12345678 after 34 cycles.
- Preload HI=0xAAAA via MTHI, start DIV, assert flush_i at 10th busy cycle -> busy_o=0 next cycle, done_o never pulses, HI=0xAAAA, LO unchanged.
- MTLO opnd1=0x1234 in IDLE -> busy_o stays 0, lo_o=0x1234 next cycle. Same with flush_i=1 -> lo_o unchanged. rst_n low mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings
// carried on mdu_op_i, sequencer state encodings and the quotient value
// reported for a divide by zero.
package mdu_ctrl_pkg;

  // Operation codes driven by EX on mdu_op_i
  localparam logic [2:0] MDU_OP_NONE  = 3'd0;
  localparam logic [2:0] MDU_OP_MULT  = 3'd1;
  localparam logic [2:0] MDU_OP_MULTU = 3'd2;
  localparam logic [2:0] MDU_OP_DIV   = 3'd3;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

  // Sequencer states; anything other than IDLE means busy
  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_e;

  // LO written on a divide by zero (all quotient bits set, no trap)
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_iter_step.sv
// Combinational single step of the iterative multiply/divide datapath.
// The accumulator is 2*WIDTH wide and shared by both modes:
//   multiply: {partial_product_hi, multiplier_remaining}; a step adds the
//             multiplicand to the upper half when the LSB is set, then
//             shifts the whole thing right by one (carry shifts in).
//   divide:   {partial_remainder, dividend_remaining/quotient}; a step
//             shifts left by one, trial-subtracts the divisor and shifts
//             in the resulting quotient bit (restoring division).
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_mode_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [WIDTH-1:0]     rem_o,
  output logic                 q_bit_o
);

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]       rem_sh;
  logic                 fits;

  // Shift-add: conditional add into the upper half, then shift right with carry
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    mul_acc = {mul_sum, acc_i[WIDTH-1:1]};
  end

  // Restoring divide: shift in next dividend bit, keep the difference if it fits.
  // When it fits the true difference is below the divisor, so a WIDTH-bit
  // modular subtract already gives the exact remainder.
  always_comb begin
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    fits    = (rem_sh >= {1'b0, opnd_i});
    q_bit_o = fits;
    rem_o   = fits ? (rem_sh[WIDTH-1:0] - opnd_i) : rem_sh[WIDTH-1:0];
  end

  // Mode select for the combined accumulator view
  always_comb begin
    if (div_mode_i) begin
      acc_o = {rem_o, acc_i[WIDTH-2:0], q_bit_o};
    end else begin
      acc_o = mul_acc;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer next to the EX-stage ALU. Owns HI/LO, runs
// MULT/MULTU/DIV/DIVU over 32 iterations plus one fix-up cycle and raises
// busy_o so the hazard unit stalls MFHI/MFLO and further MDU ops.
// Build option: define MDU_FAST_MUL_EN to replace the iterative multiply
// with a single-cycle WIDTH x WIDTH multiply (IDLE goes straight to DONE).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       mdu_op_i,
  input  logic [WIDTH-1:0] opnd1_i,
  input  logic [WIDTH-1:0] opnd2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic                 div0_q, div0_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_qbit;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  logic                 last_iter;

  mdu_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .div_mode_i (is_div_q),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (step_acc),
    .rem_o      (step_rem),
    .q_bit_o    (step_qbit)
  );

  // Operand magnitudes for signed ops; unsigned ops pass raw operands
  always_comb begin
    signed_op = (mdu_op_i == MDU_OP_MULT) || (mdu_op_i == MDU_OP_DIV);
    mag1      = (signed_op && opnd1_i[WIDTH-1]) ? -opnd1_i : opnd1_i;
    mag2      = (signed_op && opnd2_i[WIDTH-1]) ? -opnd2_i : opnd2_i;
  end

  // Sign fix-up of the finished magnitude result; a zero divisor reports
  // an all-ones quotient and leaves the dividend (as issued) as remainder,
  // which the remainder sign fix reproduces exactly
  always_comb begin
    prod_fix = neg_q_q ? -acc_q : acc_q;
    quo_fix  = div0_q ? MDU_DIV0_LO[WIDTH-1:0]
                      : (neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Next-state, datapath load/step and HI/LO update; flush overrides all
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_o   = 1'b0;

    case (state_q)
      MDU_ST_IDLE: begin
        if (start_i) begin
          case (mdu_op_i)
            MDU_OP_MULT, MDU_OP_MULTU: begin
              neg_q_d  = signed_op & (opnd1_i[WIDTH-1] ^ opnd2_i[WIDTH-1]);
              neg_r_d  = signed_op & opnd1_i[WIDTH-1];
              div0_d   = 1'b0;
              is_div_d = 1'b0;
              cnt_d    = '0;
`ifdef MDU_FAST_MUL_EN
              acc_d    = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
              state_d  = MDU_ST_DONE;
`else
              acc_d    = {{WIDTH{1'b0}}, mag2};
              opnd_d   = mag1;
              state_d  = MDU_ST_MUL;
`endif
            end
            MDU_OP_DIV, MDU_OP_DIVU: begin
              neg_q_d  = signed_op & (opnd1_i[WIDTH-1] ^ opnd2_i[WIDTH-1]);
              neg_r_d  = signed_op & opnd1_i[WIDTH-1];
              div0_d   = (opnd2_i == '0);
              is_div_d = 1'b1;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, mag1};
              opnd_d   = mag2;
              state_d  = MDU_ST_DIV;
            end
            MDU_OP_MTHI: hi_d = opnd1_i;
            MDU_OP_MTLO: lo_d = opnd1_i;
            default: ;
          endcase
        end
      end

      MDU_ST_MUL: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = MDU_ST_DONE;
        end
      end

      MDU_ST_DIV: begin
        acc_d = {step_rem, acc_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = MDU_ST_DONE;
        end
      end

      MDU_ST_DONE: begin
        done_o  = 1'b1;
        state_d = MDU_ST_IDLE;
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
      end

      default: state_d = MDU_ST_IDLE;
    endcase

    if (flush_i) begin
      state_d = MDU_ST_IDLE;
      cnt_d   = '0;
      done_o  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State, datapath and architectural register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o = (state_q != MDU_ST_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a cycle-level reference model built
// from plain 64-bit arithmetic and a remaining-cycles count, a per-cycle
// compare process, and directed vectors with hand-computed HI/LO.
// Honours MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  mdu_op_i;
  logic [31:0] opnd1_i;
  logic [31:0] opnd2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total;
  int bad;

  // Reference model state
  int          m_left;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;

  mdu_ctrl #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .mdu_op_i (mdu_op_i),
    .opnd1_i  (opnd1_i),
    .opnd2_i  (opnd2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural result {HI, LO} from plain arithmetic
  function automatic logic [63:0] model_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0]     res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      OP_MULT: begin
        sp  = sa * sb;
        res = sp;
      end
      OP_MULTU: begin
        up  = ua * ub;
        res = up;
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          uq  = ua / ub;
          ur  = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Model: m_left counts the busy cycles still to come; HI/LO land when it hits zero
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 64'd0;
    end else if (flush_i) begin
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (start_i) begin
      case (mdu_op_i)
        OP_MTHI: m_hi <= opnd1_i;
        OP_MTLO: m_lo <= opnd1_i;
        OP_MULT, OP_MULTU: begin
          m_pend <= model_result(mdu_op_i, opnd1_i, opnd2_i);
          m_left <= MUL_LAT;
        end
        OP_DIV, OP_DIVU: begin
          m_pend <= model_result(mdu_op_i, opnd1_i, opnd2_i);
          m_left <= DIV_LAT;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cyc_busy", 64'(busy_o), 64'(m_left > 0));
        chk("cyc_done", 64'(done_o), 64'((m_left == 1) && !flush_i));
        chk("cyc_hi", 64'(hi_o), 64'(m_hi));
        chk("cyc_lo", 64'(lo_o), 64'(m_lo));
        if (start_i) begin
          chk("start_while_busy", 64'(busy_o), 64'd0);
        end
      end
    end
  end

  // Single-cycle MTHI/MTLO issue with optional flush
  task automatic mt_op(input logic [2:0] op, input logic [31:0] val, input logic fl);
    @(posedge clk); #1;
    start_i  = 1'b1;
    mdu_op_i = op;
    opnd1_i  = val;
    flush_i  = fl;
    @(posedge clk); #1;
    start_i  = 1'b0;
    mdu_op_i = OP_NONE;
    flush_i  = 1'b0;
    $display("op=%0d data=%h flush=%0b -> hi=%h lo=%h busy=%0b", op, val, fl, hi_o, lo_o, busy_o);
  endtask

  // Issue a MUL/DIV op; leaves the bench in the first busy cycle (#1 after the start edge)
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start_i  = 1'b1;
    mdu_op_i = op;
    opnd1_i  = a;
    opnd2_i  = b;
    @(posedge clk); #1;
    start_i  = 1'b0;
    mdu_op_i = OP_NONE;
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int busy_n;
    int done_n;
    int lat;
    busy_n = 0;
    done_n = 0;
    lat = ((op == OP_MULT) || (op == OP_MULTU)) ? MUL_LAT : DIV_LAT;
    issue(op, a, b);
    while (busy_o && busy_n < 200) begin
      if (done_o) done_n++;
      busy_n++;
      @(posedge clk); #1;
    end
    chk({name, "_busy_cycles"}, 64'(busy_n), 64'(lat));
    chk({name, "_done_pulses"}, 64'(done_n), 64'd1);
    chk({name, "_hi"}, 64'(hi_o), 64'(ehi));
    chk({name, "_lo"}, 64'(lo_o), 64'(elo));
    chk({name, "_model_hi"}, 64'(m_hi), 64'(ehi));
    chk({name, "_model_lo"}, 64'(m_lo), 64'(elo));
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", name, op, a, b, hi_o, lo_o, busy_n);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int busy_n;
    int done_n;

    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    mdu_op_i = OP_NONE;
    opnd1_i  = 32'd0;
    opnd2_i  = 32'd0;
    flush_i  = 1'b0;

    vecs[0] = '{"mult_neg2x3",  OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{"multu_big_x3", OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{"div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_100_7",   OP_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[4] = '{"divu_by0",     OP_DIVU,  32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{"div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{"div_by0_neg",  OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{"mult_7_m3",    OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[8] = '{"div_7_m2",     OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{"multu_max_sq", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_hi", 64'(hi_o), 64'd0);
    chk("rst_lo", 64'(lo_o), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // MTLO in IDLE, then MTLO with flush (discarded)
    mt_op(OP_MTLO, 32'h0000_1234, 1'b0);
    chk("mtlo_lo", 64'(lo_o), 64'h1234);
    chk("mtlo_busy", 64'(busy_o), 64'd0);
    mt_op(OP_MTLO, 32'h0000_5555, 1'b1);
    chk("mtlo_flush_lo", 64'(lo_o), 64'h1234);

    // Flush a divide on its 10th busy cycle
    mt_op(OP_MTHI, 32'h0000_AAAA, 1'b0);
    chk("mthi_hi", 64'(hi_o), 64'hAAAA);
    issue(OP_DIV, 32'd100, 32'd7);
    done_n = 0;
    repeat (9) begin
      if (done_o) done_n++;
      @(posedge clk); #1;
    end
    chk("flush_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    if (done_o) done_n++;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy_after", 64'(busy_o), 64'd0);
    repeat (30) begin
      if (done_o) done_n++;
      @(posedge clk); #1;
    end
    chk("flush_done_pulses", 64'(done_n), 64'd0);
    chk("flush_hi", 64'(hi_o), 64'hAAAA);
    chk("flush_lo", 64'(lo_o), 64'h1234);
    $display("flush div -> hi=%h lo=%h busy=%0b", hi_o, lo_o, busy_o);

    // Asynchronous reset in the middle of a multiply
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_hi", 64'(hi_o), 64'd0);
    chk("midrst_lo", 64'(lo_o), 64'd0);
    $display("reset mid-mult -> hi=%h lo=%h busy=%0b", hi_o, lo_o, busy_o);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Recovery after reset
    run_op("post_rst_multu", OP_MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A);

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
